// File: rtl/move_sequencer.sv
// Scripted move player for the score4 core: replays stored NOP/RIGHT/LEFT/PUT
// moves as fixed-width pulses, each followed by a wait of N vsync frames.
module move_sequencer #(
    parameter int DEPTH          = 64,
    parameter int PULSE_CYCLES   = 10,
    parameter int FRAMES_DEFAULT = 1,
    parameter int FRW            = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [1:0]                 wr_op,
    input  logic [$clog2(DEPTH):0]     length,
    input  logic [FRW-1:0]             frames_cfg,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_mode,
    input  logic                       halt_on_end,
    input  logic                       vsync,
    input  logic                       win_a,
    input  logic                       win_b,
    input  logic                       full_panel,
    output logic                       left,
    output logic                       right,
    output logic                       put,
    output logic                       busy,
    output logic                       done,
    output logic                       halted,
    output logic [$clog2(DEPTH)-1:0]   move_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int DW = $clog2(FRAMES_DEFAULT + 1);
    localparam int FW = (FRW > DW) ? FRW : DW;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L   = (AW + 1)'(1);
    localparam logic [PW-1:0] PC      = PW'(PULSE_CYCLES);
    localparam logic [FW-1:0] FONE    = FW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ADV    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [1:0]    script [DEPTH];
    logic [2:0]    state;
    logic [PW-1:0] pcnt;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] frames_q;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic          halt_q;
    logic          vsync_q;

    logic [AW:0]   len_clamped;
    logic [FW-1:0] frames_eff;
    logic [1:0]    op_cur;
    logic          fe;
    logic          last;
    logic          game_over;

    assign len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
    assign frames_eff  = (frames_cfg == '0) ? FW'(FRAMES_DEFAULT)
                                            : FW'(frames_cfg);
    assign op_cur      = script[move_idx];
    assign fe          = vsync_q & ~vsync;
    assign last        = ({1'b0, move_idx} == (len_q - ONE_L));
    assign game_over   = win_a | win_b | full_panel;

    // Writes are blocked during playback, so an async read stays stable.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            script[wr_addr] <= wr_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            left     <= 1'b0;
            right    <= 1'b0;
            put      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            halted   <= 1'b0;
            move_idx <= '0;
            vsync_q  <= 1'b1;
            pcnt     <= '0;
            fcnt     <= '0;
            frames_q <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            done    <= 1'b0;
            if (abort && state != S_IDLE && state != S_FINISH) begin
                left   <= 1'b0;
                right  <= 1'b0;
                put    <= 1'b0;
                halted <= 1'b1;
                state  <= S_FINISH;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            len_q    <= len_clamped;
                            frames_q <= frames_eff;
                            loop_q   <= loop_mode;
                            halt_q   <= halt_on_end;
                            if (len_clamped != '0) begin
                                state    <= S_ISSUE;
                                busy     <= 1'b1;
                                move_idx <= '0;
                                halted   <= 1'b0;
                                pcnt     <= '0;
                            end else begin
                                state <= S_FINISH;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (pcnt != PC) begin
                            pcnt  <= pcnt + PW'(1);
                            right <= (op_cur == 2'b01);
                            left  <= (op_cur == 2'b10);
                            put   <= (op_cur == 2'b11);
                        end else begin
                            left  <= 1'b0;
                            right <= 1'b0;
                            put   <= 1'b0;
                            fcnt  <= frames_q;
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (fe) begin
                            fcnt <= fcnt - FONE;
                            if (fcnt <= FONE)
                                state <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        pcnt <= '0;
                        if (halt_q && game_over) begin
                            halted <= 1'b1;
                            state  <= S_FINISH;
                        end else if (last) begin
                            if (loop_q) begin
                                move_idx <= '0;
                                state    <= S_ISSUE;
                            end else begin
                                state <= S_FINISH;
                            end
                        end else begin
                            move_idx <= move_idx + AW'(1);
                            state    <= S_ISSUE;
                        end
                    end
                    S_FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Synthesizable, parametrised move player for the score4 game core.
- Stores a script of moves (NOP/RIGHT/LEFT/PUT) and replays it on the core's left/right/put inputs.
- Each move is a fixed-width pulse, followed by a wait of a programmable number of VGA frames. This replaces hand-driven move stimulus and allows on-board demo and regression playback.
- Adds loop mode and halt-on-game-over, which the hand-driven flow does not have.

Parameters:
- DEPTH, 64, number of script entries (power of two, >=2).
- PULSE_CYCLES, 10, clock cycles each move pulse is held high (>=1).
- FRAMES_DEFAULT, 1, vsync falling edges to wait after each move when frames_cfg is 0.
- FRW, 4, width of frames_cfg.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst, in, 1, synchronous active-high reset.
- wr_en, in, 1, script write strobe; ignored while busy.
- wr_addr, in, log2(DEPTH), script write address.
- wr_op, in, 2, move code: 00 NOP, 01 RIGHT, 10 LEFT, 11 PUT.
- length, in, log2(DEPTH)+1, number of valid entries (0..DEPTH); sampled at start.
- frames_cfg, in, FRW, frames to wait per move; 0 selects FRAMES_DEFAULT; sampled at start.
- start, in, 1, begin playback from entry 0 (single-cycle pulse).
- abort, in, 1, stop playback.
- loop_mode, in, 1, on reaching length, wrap to entry 0 instead of finishing; sampled at start.
- halt_on_end, in, 1, stop when the game ends; sampled at start.
- vsync, in, 1, VGA vsync from the core, active low.
- win_a, in, 1, game-over status from the core.
- win_b, in, 1, game-over status from the core.
- full_panel, in, 1, game-over status from the core.
- left, out, 1, move pulse to the core.
- right, out, 1, move pulse to the core.
- put, out, 1, move pulse to the core.
- busy, out, 1, playback in progress.
- done, out, 1, one-cycle pulse on playback end.
- halted, out, 1, sticky flag: last playback ended by game-over or abort.
- move_idx, out, log2(DEPTH), index of the current or next entry.

Behaviour:
- All outputs are registered.
- Reset values:
  - left, right, put, busy, done, halted, move_idx = 0.
  - FSM = IDLE.
  - vsync_q = 1.
  - Script RAM contents are not reset.
- Script writes: RAM is written on wr_en & ~busy at wr_addr. A write and start in the same cycle: the write lands first, so the new value is played.
- Frame edge: fe = vsync_q & ~vsync, where vsync_q is vsync registered once.
- FSM states: IDLE, ISSUE, WAIT_FRAME, ADVANCE, FINISH.
- IDLE:
  - start with length>0 → ISSUE; busy=1, move_idx=0, halted cleared.
  - start with length=0 → FINISH.
- ISSUE:
  - Drive the output selected by the op at move_idx for exactly PULSE_CYCLES cycles. The first high cycle is the cycle after the state is entered.
  - At most one of left/right/put is high at any time. NOP drives all three low for the same duration.
  - Then → WAIT_FRAME with frame counter = effective frames.
- WAIT_FRAME:
  - Decrement the counter on each fe.
  - Reaching 0 → ADVANCE.
  - An fe in the first cycle of WAIT_FRAME counts.
- ADVANCE (1 cycle):
  - If halt_on_end and (win_a|win_b|full_panel) → FINISH with halted=1.
  - Else if move_idx==length-1: loop_mode → move_idx=0, ISSUE; otherwise → FINISH.
  - Else move_idx+1, ISSUE.
- FINISH (1 cycle): done=1, busy=0 the following cycle, → IDLE. move_idx holds its final value.
- abort:
  - In any non-IDLE state, abort forces the outputs low the next cycle, sets halted=1, and goes to FINISH. An in-flight pulse is truncated.
  - Abort in IDLE is ignored.
- start while busy is ignored.
- Game-over is checked only in ADVANCE, so a move is never truncated by game-over.
- Simultaneous abort and start in IDLE: start wins, abort is ignored.
- Reset mid-playback: all outputs drop the next cycle and the FSM goes to IDLE.
- Length above DEPTH is clamped to DEPTH.
- Pulse counter width: clog2(PULSE_CYCLES+1).

Test Plan:
- Load ops [PUT,RIGHT,PUT], length=3, frames_cfg=1; start; model vsync with a 1000-cycle period → put high 10 cycles, then right 10 cycles after the next vsync fall, then put; done pulse once; move_idx=2; halted=0.
- Check frame-wait count, frames_cfg=3, 2 entries → gap between pulse starts = 3 vsync falls (±1 frame phase); frames_cfg=0 gives FRAMES_DEFAULT=1.
- Loop mode: loop_mode=1, length=2 → sequence repeats ≥3 times; move_idx wraps 1→0; abort → outputs low the next cycle, done pulse, halted=1.
- halt_on_end: assert win_a during the second move's WAIT_FRAME, length=5 → finishes after move 2; halted=1; move_idx=1; the in-progress pulse is full width.
- Edge cases: start with length=0 → done one cycle later, no pulses. A write while busy does not alter the played op. Reset during ISSUE → put low the next cycle and busy=0.
- Invariant (checked all runs): left+right+put ≤ 1 every cycle; every pulse is exactly PULSE_CYCLES long unless aborted or reset.
